// File: rtl/fft_pingpong_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_pingpong_ram_if
// Function : Host-side and core-side access signals of the ping-pong sample RAM
// Revision : 1.0
// ============================================================================
interface fft_pingpong_ram_if #(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 4096,
  parameter int ADDR_W   = $clog2(DEPTH)
);
  logic                  host_wr;
  logic                  host_rd;
  logic [ADDR_W-1:0]     host_addr;
  logic [SAMPLE_W-1:0]   host_wdata;
  logic [2*SAMPLE_W-1:0] host_rdata;
  logic                  host_rvalid;
  logic                  host_frame_done;
  logic                  host_ready;
  logic                  core_we;
  logic                  core_re;
  logic [ADDR_W-1:0]     core_addr;
  logic [2*SAMPLE_W-1:0] core_wdata;
  logic [2*SAMPLE_W-1:0] core_rdata;
  logic                  core_rvalid;
  logic                  core_frame_done;
  logic                  core_ready;
  logic                  swap;
  logic [15:0]           frame_cnt;

  modport slave (
    input  host_wr, host_rd, host_addr, host_wdata, host_frame_done,
    input  core_we, core_re, core_addr, core_wdata, core_frame_done,
    output host_rdata, host_rvalid, host_ready,
    output core_rdata, core_rvalid, core_ready,
    output swap, frame_cnt
  );

  modport master (
    output host_wr, host_rd, host_addr, host_wdata, host_frame_done,
    output core_we, core_re, core_addr, core_wdata, core_frame_done,
    input  host_rdata, host_rvalid, host_ready,
    input  core_rdata, core_rvalid, core_ready,
    input  swap, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fft_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_pingpong_ram
// Function : Two-bank sample memory; host and core own opposite banks and
//            exchange them on a two-sided frame handshake.
//            Define FFT_RAM_BITREV_EN to bit-reverse host write addresses.
// Revision : 1.0
// ============================================================================
module fft_pingpong_ram #(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 4096
) (
  input  wire                  clk,
  input  wire                  rst,
  fft_pingpong_ram_if.slave    bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WORD_W = 2 * SAMPLE_W;

  logic [WORD_W-1:0] mem0 [DEPTH];
  logic [WORD_W-1:0] mem1 [DEPTH];

  logic              sel_q, sel_d;
  logic              host_fin_q, host_fin_d;
  logic              core_fin_q, core_fin_d;
  logic              swap_q, swap_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [WORD_W-1:0] host_rdata_q, host_rdata_d;
  logic [WORD_W-1:0] core_rdata_q, core_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              core_rvalid_q, core_rvalid_d;

  logic              host_wr_en, host_rd_en, core_wr_en, core_rd_en;
  logic              do_swap;
  logic [ADDR_W-1:0] host_waddr;
  logic [WORD_W-1:0] host_word;
  logic              mem0_we, mem1_we;
  logic [ADDR_W-1:0] mem0_waddr, mem1_waddr;
  logic [WORD_W-1:0] mem0_wdata, mem1_wdata;

`ifdef FFT_RAM_BITREV_EN
  // Decimation-in-time input ordering for the core
  always_comb begin
    host_waddr = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      host_waddr[i] = bus.host_addr[ADDR_W-1-i];
    end
  end
`else
  assign host_waddr = bus.host_addr;
`endif

  assign host_word  = {{SAMPLE_W{1'b0}}, bus.host_wdata};
  assign host_wr_en = bus.host_wr & ~host_fin_q;
  assign host_rd_en = bus.host_rd & ~host_fin_q;
  assign core_wr_en = bus.core_we & ~core_fin_q;
  assign core_rd_en = bus.core_re & ~core_fin_q;
  assign do_swap    = host_fin_q & core_fin_q;

  // Host owns bank sel, core owns the other; each bank has one writer at a time
  always_comb begin
    mem0_we    = sel_q ? core_wr_en    : host_wr_en;
    mem0_waddr = sel_q ? bus.core_addr : host_waddr;
    mem0_wdata = sel_q ? bus.core_wdata : host_word;
    mem1_we    = sel_q ? host_wr_en    : core_wr_en;
    mem1_waddr = sel_q ? host_waddr    : bus.core_addr;
    mem1_wdata = sel_q ? host_word     : bus.core_wdata;
  end

  always_ff @(posedge clk) begin
    if (mem0_we) mem0[mem0_waddr] <= mem0_wdata;
    if (mem1_we) mem1[mem1_waddr] <= mem1_wdata;
  end

  always_comb begin
    sel_d         = sel_q;
    host_fin_d    = host_fin_q | bus.host_frame_done;
    core_fin_d    = core_fin_q | bus.core_frame_done;
    swap_d        = do_swap;
    frame_cnt_d   = frame_cnt_q;
    host_rdata_d  = host_rdata_q;
    core_rdata_d  = core_rdata_q;
    host_rvalid_d = host_rd_en;
    core_rvalid_d = core_rd_en;

    if (do_swap) begin
      sel_d       = ~sel_q;
      // A done pulse coinciding with the swap lands in the freshly cleared flag
      host_fin_d  = bus.host_frame_done;
      core_fin_d  = bus.core_frame_done;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Reads sample the array before this edge's write: read-first
    if (host_rd_en) host_rdata_d = sel_q ? mem1[bus.host_addr] : mem0[bus.host_addr];
    if (core_rd_en) core_rdata_d = sel_q ? mem0[bus.core_addr] : mem1[bus.core_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q         <= 1'b0;
      host_fin_q    <= 1'b0;
      core_fin_q    <= 1'b1;
      swap_q        <= 1'b0;
      frame_cnt_q   <= 16'd0;
      host_rdata_q  <= '0;
      core_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      core_rvalid_q <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      host_fin_q    <= host_fin_d;
      core_fin_q    <= core_fin_d;
      swap_q        <= swap_d;
      frame_cnt_q   <= frame_cnt_d;
      host_rdata_q  <= host_rdata_d;
      core_rdata_q  <= core_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      core_rvalid_q <= core_rvalid_d;
    end
  end

  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_ready  = ~host_fin_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_ready  = ~core_fin_q;
  assign bus.swap        = swap_q;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule
`default_nettype wire

// File: doc/fft_pingpong_ram.md
Name: fft_pingpong_ram

Overview:
- Parametrised double-buffered sample memory between the AXI-side host and the FFT butterfly core.
- Two banks of DEPTH complex words. The host fills one bank with real samples and reads back results, while the core works in place on the other bank.
- Bank ownership swaps on a two-sided frame handshake, so host and core never touch the same bank.

Parameters:
- SAMPLE_W, 16, width of one real or imaginary component.
- DEPTH, 4096, words per bank; power of two, minimum 4.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- host_wr  in  1  host write strobe.
- host_rd  in  1  host read strobe.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  SAMPLE_W  real sample; stored as {imag=0, real=host_wdata}.
- host_rdata  out  2*SAMPLE_W  {imag, real} read data.
- host_rvalid  out  1  host_rdata valid.
- host_frame_done  in  1  one-cycle pulse: host finished with its bank.
- host_ready  out  1  host owns a bank and may access it.
- core_we  in  1  core write strobe.
- core_re  in  1  core read strobe.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  2*SAMPLE_W  {imag, real}.
- core_rdata  out  2*SAMPLE_W  read data.
- core_rvalid  out  1  core_rdata valid.
- core_frame_done  in  1  one-cycle pulse: core finished its FFT.
- core_ready  out  1  core owns a bank and may access it.
- swap  out  1  one-cycle pulse when the banks exchange owners.
- frame_cnt  out  16  number of swaps since reset; wraps 0xFFFF to 0.

Behaviour:
- Storage: mem0 and mem1, each DEPTH x 2*SAMPLE_W. Contents are not reset.
- Bank selection: register sel. The host accesses bank sel; the core accesses bank ~sel.
- Handshake flags: host_fin and core_fin.
  - host_fin sets on host_frame_done; core_fin sets on core_frame_done.
  - host_ready = ~host_fin; core_ready = ~core_fin.
- Swap rule: when host_fin and core_fin are both 1 at a clock edge:
  - sel toggles and both flags clear;
  - swap = 1 for that cycle, registered (visible the cycle after the flags are both set);
  - frame_cnt increments.
- Done pulse in the same cycle as a swap: the pulse is registered into the already-cleared flag. It is not lost.
- Reset values:
  - sel=0, host_fin=0, core_fin=1 (the core starts idle, so the first host_frame_done swaps), swap=0, frame_cnt=0;
  - host_rdata=0, core_rdata=0, host_rvalid=0, core_rvalid=0.
- Reset asserted mid-frame aborts the frame; the state returns to the reset values.
- Write timing: a write commits at the clock edge.
- Read timing: registered, latency 1.
  - rdata and rvalid appear on the cycle after the strobe.
  - rvalid is low otherwise; rdata holds its last value.
- Read and write to the same address in the same cycle (one port): read-first, so the old data is returned.
- Access gating: access while not ready (host_fin or core_fin set) is dropped; no write, no rvalid.
- Port isolation: the ports address different banks, so there are no cross-port collisions.
- Accesses in the swap cycle use the pre-swap sel.
- host_wr and host_rd together: both are performed, read-first.
- Addresses are full range; no wrap logic is needed.

Optional Feature:
- Macro: FFT_RAM_BITREV_EN.
- Defined: host writes land at bit-reversed(host_addr) over ADDR_W bits, so the core sees samples in decimation-in-time order. Host reads and core accesses stay unmodified.
- Undefined: host writes use host_addr directly.

Test Plan:
- Reset, then host writes 0x1234 at addr 5, then host_frame_done → swap pulses, frame_cnt=1, sel=1; core reads addr 5 → core_rdata=0x00001234 with core_rvalid one cycle later.
- Core writes 0xABCD0001 at addr 7, core_frame_done; host writes a new frame, host_frame_done → second swap, frame_cnt=2; host reads addr 7 → 0xABCD0001.
- After host_frame_done and before core_frame_done: host write at addr 3 → ignored, host_rvalid stays 0, host_ready=0; bank contents unchanged.
- host_frame_done and core_frame_done in the same cycle → exactly one swap pulse, both readies return to 1 one cycle later.
- Assert rst while host_fin=1 and frame_cnt=3 → immediately host_rvalid=0, swap=0, frame_cnt=0, sel=0, core_ready=0.
- With FFT_RAM_BITREV_EN and DEPTH=8: host writes 0x0011 at addr 1, swap → core reads addr 4 → 0x00000011.
